// File: rtl/uart_program_loader.sv
// uart_program_loader: frames a UART byte stream into program memory writes and holds the CPU in reset until a good image lands.
module uart_program_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] pc_address,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset_n,
  output logic        loading,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  localparam logic [2:0] WAIT_SYNC = 3'd0;
  localparam logic [2:0] LEN_LO    = 3'd1;
  localparam logic [2:0] LEN_HI    = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;
  localparam logic [2:0] RUN       = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;
  logic [2:0]  state;
  logic [15:0] len;
  logic [7:0]  chk;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [31:0] timer;
  logic [15:0] len_next;
  logic        too_long;
  logic        timed_out;
  assign loading     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign len_next    = {rx_data, len[7:0]};
  assign too_long    = {16'b0, len_next} > MEM_WORDS;
  assign timed_out   = (TIMEOUT_CYCLES != 0) && loading && !rx_valid && (timer == TIMEOUT_CYCLES - 1);
  assign mem_address = cpu_reset_n ? pc_address : BASE_ADDR + {14'b0, words_loaded, 2'b0};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= WAIT_SYNC;
      len              <= '0;
      chk              <= '0;
      byte_idx         <= '0;
      word_buf         <= '0;
      timer            <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      cpu_reset_n      <= 1'b0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
      words_loaded     <= '0;
    end else begin
      load_done        <= 1'b0;
      mem_write_enable <= 1'b0;
      timer            <= (rx_valid || !loading) ? 32'd0 : timer + 32'd1;
      // the count advances on the strobe cycle so the strobe sees the pre-increment address
      if (mem_write_enable) words_loaded <= words_loaded + 16'd1;
      if (timed_out) begin
        state      <= ERROR;
        load_error <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          WAIT_SYNC, RUN, ERROR: begin
            if (rx_data == SYNC_BYTE) begin
              state        <= LEN_LO;
              cpu_reset_n  <= 1'b0;
              load_error   <= 1'b0;
              words_loaded <= '0;
              chk          <= '0;
              byte_idx     <= '0;
            end
          end
          LEN_LO: begin
            len[7:0] <= rx_data;
            chk      <= chk ^ rx_data;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            len[15:8]  <= rx_data;
            chk        <= chk ^ rx_data;
            load_error <= too_long;
            state      <= too_long ? ERROR : (len_next == 16'd0) ? CHECK : DATA;
          end
          DATA: begin
            chk      <= chk ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {rx_data, word_buf[23:8]};
            if (byte_idx == 2'd3) begin
              mem_write_data   <= {rx_data, word_buf};
              mem_write_enable <= 1'b1;
              if (words_loaded + 16'd1 == len) state <= CHECK;
            end
          end
          CHECK: begin
            state       <= (rx_data == chk) ? RUN : ERROR;
            cpu_reset_n <= rx_data == chk;
            load_done   <= rx_data == chk;
            load_error  <= rx_data != chk;
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: randomized frames against a frame-level model, scoreboarded writes and completion events.
module tb_uart_program_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int MW = 8;
  localparam int TO = 100;
  logic clk = 0, reset_n = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] pc_address = 0;
  logic [31:0] mem_address, mem_write_data;
  logic mem_write_enable, cpu_reset_n, loading, load_done, load_error;
  logic [15:0] words_loaded;
  always #5 clk = ~clk;
  uart_program_loader #(.SYNC_BYTE(8'hA5), .MEM_WORDS(MW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .pc_address(pc_address),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .cpu_reset_n(cpu_reset_n), .loading(loading), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded));
  typedef struct {bit err; int words;} ev_t;
  ev_t exp_ev[$];
  logic [63:0] exp_wr[$];
  logic [31:0] pay[$];
  int n_cmp = 0, n_bad = 0;
  logic prev_err = 0;
  logic [63:0] mon_w;
  ev_t mon_e;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_ev(input bit err, input int words);
    ev_t e;
    e.err = err;
    e.words = words;
    exp_ev.push_back(e);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back($urandom);
  endtask
  // expected outcome derived from the frame format alone: byte list, checksum, writes, final event
  task automatic run_frame(input logic [15:0] n, input bit bad, input int maxgap);
    logic [7:0] bytes[$];
    logic [7:0] c;
    logic [31:0] d;
    bytes.push_back(8'hA5);
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    c = n[7:0] ^ n[15:8];
    if (n > MW) push_ev(1'b1, 0);
    else begin
      for (int w = 0; w < int'(n); w++) begin
        d = pay[w];
        exp_wr.push_back({BASE + 32'(4 * w), d});
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(d[8*k +: 8]);
          c ^= d[8*k +: 8];
        end
      end
      bytes.push_back(bad ? c ^ 8'($urandom_range(1, 255)) : c);
      push_ev(bad, int'(n));
    end
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, maxgap));
    repeat (3) @(negedge clk);
    if (n <= MW) check("words_after_frame", {16'b0, words_loaded}, {16'b0, n});
    check("cpu_rst_after_frame", {31'b0, cpu_reset_n}, {31'b0, (n <= MW) && !bad});
  endtask
  always @(posedge clk) begin
    #2;
    if (reset_n) begin
      if (mem_write_enable) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", mem_address, mem_write_data);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", mem_address, mon_w[63:32]);
          check("wr_data", mem_write_data, mon_w[31:0]);
          check("wr_cpu_rst", {31'b0, cpu_reset_n}, 32'd0);
        end
      end
      if (load_done || (load_error && !prev_err)) begin
        if (exp_ev.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got done=%0d error=%0d expected none", load_done, load_error);
        end else begin
          mon_e = exp_ev.pop_front();
          check("ev_err", {31'b0, load_error}, {31'b0, mon_e.err});
          check("ev_done", {31'b0, load_done}, {31'b0, !mon_e.err});
          check("ev_words", {16'b0, words_loaded}, 32'(mon_e.words));
          check("ev_cpu_rst", {31'b0, cpu_reset_n}, {31'b0, !mon_e.err});
        end
      end
    end
    prev_err = load_error;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    logic [7:0] g;
    #1;
    check("rst_cpu", {31'b0, cpu_reset_n}, 0);
    check("rst_we", {31'b0, mem_write_enable}, 0);
    check("rst_wd", mem_write_data, 0);
    check("rst_loading", {31'b0, loading}, 0);
    check("rst_done", {31'b0, load_done}, 0);
    check("rst_err", {31'b0, load_error}, 0);
    check("rst_words", {16'b0, words_loaded}, 0);
    check("rst_addr", mem_address, BASE);
    #20;
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    pay = '{32'h0000_0013, 32'h0010_0093};
    run_frame(16'd2, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      pc_address = $urandom;
      #1 check("pc_mux", mem_address, pc_address);
    end
    @(negedge clk);
    run_frame(16'd2, 1'b1, 2);
    check("err_sticky", {31'b0, load_error}, 1);
    run_frame(16'd2, 1'b0, 2);
    check("err_cleared", {31'b0, load_error}, 0);
    run_frame(16'(MW + 1), 1'b0, 0);
    run_frame(16'hFFFF, 1'b0, 1);
    fill_pay(MW);
    run_frame(16'(MW), 1'b0, 0);
    push_ev(1'b1, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    k = 0;
    while (!load_error && k < 200) begin
      @(posedge clk);
      #3 k++;
    end
    check("timeout_cycles", k, TO);
    @(negedge clk);
    fill_pay(1);
    run_frame(16'd1, 1'b0, 3);
    send_byte(8'hA5, 0);
    check("reload_cpu_rst", {31'b0, cpu_reset_n}, 0);
    check("reload_addr", mem_address, BASE);
    check("reload_loading", {31'b0, loading}, 1);
    push_ev(1'b0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("zero_frame_run", {31'b0, cpu_reset_n}, 1);
    fill_pay(3);
    exp_wr.push_back({BASE, pay[0]});
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(pay[i / 4][8*(i % 4) +: 8], 1);
    #2 reset_n = 0;
    #1;
    check("arst_cpu", {31'b0, cpu_reset_n}, 0);
    check("arst_we", {31'b0, mem_write_enable}, 0);
    check("arst_wd", mem_write_data, 0);
    check("arst_loading", {31'b0, loading}, 0);
    check("arst_err", {31'b0, load_error}, 0);
    check("arst_words", {16'b0, words_loaded}, 0);
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    push_ev(1'b0, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("post_rst_words", {16'b0, words_loaded}, 0);
    check("post_rst_cpu", {31'b0, cpu_reset_n}, 1);
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      fill_pay(MW);
      run_frame(16'($urandom_range(0, MW + 2)), ($urandom % 4) == 0, $urandom_range(0, 5));
    end
    repeat (5) @(negedge clk);
    check("writes_drained", exp_wr.size(), 0);
    check("events_drained", exp_ev.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
